// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ
// valid/ready/last requesters, granting bursts of up to MAXBURST words.
module fifo_wr_arb #(
    parameter int DSIZE    = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(MAXBURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic [BW-1:0]   beat;

    logic [IW-1:0]   pick;
    logic            found;
    logic [IW:0]     scan;
    logic [IW-1:0]   owner_nxt;
    logic            xfer;
    logic            last_beat;

    // Pick the first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        scan  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, rr_ptr} + (IW+1)'(i);
            if (scan >= (IW+1)'(NREQ))
                scan = scan - (IW+1)'(NREQ);
            if (!found && req_valid[scan[IW-1:0]]) begin
                found = 1'b1;
                pick  = scan[IW-1:0];
            end
        end
    end

    // Datapath and handshake decode from the registered owner.
    always_comb begin
        busy      = (state == BURST);
        xfer      = busy && req_valid[owner] && !wfull;
        last_beat = req_last[owner] || (beat == BW'(MAXBURST - 1));
        owner_nxt = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
        winc      = xfer;
        req_ready = xfer ? (NREQ'(1) << owner) : '0;
        gnt       = busy ? (NREQ'(1) << owner) : '0;
        wdata     = busy ? req_data[owner*DSIZE +: DSIZE] : '0;
    end

    // Arbitration FSM: one idle cycle to choose, then the burst.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            beat   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        owner <= pick;
                        beat  <= '0;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        if (last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= owner_nxt;
                            beat   <= '0;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end else if (!req_valid[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= owner_nxt;
                        beat   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: requester models feed packets and a
// scoreboard of expected FIFO words is checked on every winc.
module tb_fifo_wr_arb;

    localparam int DSIZE    = 8;
    localparam int NREQ     = 4;
    localparam int MAXBURST = 4;
    localparam int DEPTH    = 32;

    logic                  wclk;
    logic                  wrst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [NREQ-1:0]       gnt;
    logic                  busy;

    fifo_wr_arb #(
        .DSIZE    (DSIZE),
        .NREQ     (NREQ),
        .MAXBURST (MAXBURST)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .gnt       (gnt),
        .busy      (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int errors = 0;
    int checks = 0;

    logic [7:0]      pd [NREQ][DEPTH];
    logic            pl [NREQ][DEPTH];
    int              rd [NREQ];
    int              wr [NREQ];
    logic [7:0]      sb [$];
    logic [NREQ-1:0] glog [$];

    logic [NREQ-1:0] sg;
    logic [NREQ-1:0] sready;
    logic            sw;
    logic            sbusy;
    logic [NREQ-1:0] fire;
    logic [7:0]      expd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int i, input logic [7:0] d, input logic l);
        pd[i][wr[i]] = d;
        pl[i][wr[i]] = l;
        wr[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (rd[i] < wr[i]);
            req_last[i]  = req_valid[i] ? pl[i][rd[i]] : 1'b0;
            req_data[i*DSIZE +: DSIZE] = req_valid[i] ? pd[i][rd[i]] : 8'h00;
        end
    endtask

    task automatic flush();
        for (int i = 0; i < NREQ; i++) rd[i] = wr[i];
    endtask

    // One clock: sample at negedge, score writes, advance requesters.
    task automatic step();
        @(negedge wclk);
        sg     = gnt;
        sw     = winc;
        sbusy  = busy;
        sready = req_ready;
        chk("winc_with_wfull", {31'b0, winc & wfull}, 32'd0);
        if (winc) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write observed=%0h expected=none", wdata);
            end else begin
                expd = sb.pop_front();
                chk("wdata", {24'b0, wdata}, {24'b0, expd});
            end
        end
        fire = req_valid & req_ready;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (fire[i]) rd[i]++;
        drive();
    endtask

    task automatic drain(input string tag, input int budget, output int n);
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=%0d left expected=0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int n;
        int cur;
        logic [NREQ-1:0] prev;

        wrst_n    = 1'b0;
        wfull     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end

        // Reset with every requester valid; 8-word packets, no last.
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++)
                put(i, 8'(16 * i + k), 1'b0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++)
                for (int k = 0; k < 4; k++)
                    sb.push_back(8'(16 * i + 4 * r + k));
        drive();
        repeat (3) @(negedge wclk);
        chk("rst_gnt",   {28'b0, gnt},       32'd0);
        chk("rst_winc",  {31'b0, winc},      32'd0);
        chk("rst_ready", {28'b0, req_ready}, 32'd0);
        chk("rst_busy",  {31'b0, busy},      32'd0);
        chk("rst_wdata", {24'b0, wdata},     32'd0);
        #1 wrst_n = 1'b1;

        // Round-robin over all four with full bursts.
        n    = 0;
        cur  = 0;
        prev = '0;
        while (sb.size() > 0 && n < 200) begin
            step();
            n++;
            if (n == 1) chk("gnt_after_reset", {28'b0, sg}, 32'd1);
            if (sg != 0 && prev == 0) glog.push_back(sg);
            prev = sg;
            if (sw) cur++;
            if (sg == 0 && cur > 0) begin
                chk("burst_len", cur, 32'd4);
                cur = 0;
            end
        end
        chk("burst_len_last", cur, 32'd4);
        chk("rr_cycles", n, 32'd39);
        chk("gnt_count", glog.size(), 32'd8);
        for (int k = 0; k < 8; k++)
            chk("gnt_seq", {28'b0, glog[k]}, 32'(1 << (k % 4)));

        // Early last from requester 2.
        put(2, 8'hA1, 1'b0);
        put(2, 8'hA2, 1'b1);
        sb.push_back(8'hA1);
        sb.push_back(8'hA2);
        drive();
        step();
        chk("early_idle", {28'b0, sg}, 32'd0);
        cur = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (sw) cur++;
            chk("early_gnt", {28'b0, sg}, 32'b0100);
        end
        chk("early_count", cur, 32'd2);
        step();
        chk("early_end_idle", {31'b0, sbusy}, 32'd0);

        // rr_ptr now 3: requester 3 must win over requester 0.
        put(0, 8'hB0, 1'b1);
        put(3, 8'hB3, 1'b1);
        sb.push_back(8'hB3);
        sb.push_back(8'hB0);
        drive();
        drain("rr_after_last", 20, n);

        // Full stall mid-burst on requester 1.
        for (int k = 0; k < 6; k++) put(1, 8'(8'hC0 + k), 1'b0);
        for (int k = 0; k < 4; k++) sb.push_back(8'(8'hC0 + k));
        drive();
        step();
        step();
        step();
        chk("stall_pre", {31'b0, sw}, 32'd1);
        wfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_winc",  {31'b0, sw},     32'd0);
            chk("stall_ready", {28'b0, sready}, 32'd0);
            chk("stall_gnt",   {28'b0, sg},     32'b0010);
        end
        wfull = 1'b0;
        step();
        chk("resume_winc", {31'b0, sw}, 32'd1);
        step();
        chk("resume_winc2", {31'b0, sw}, 32'd1);
        step();
        chk("stall_burst_end", {31'b0, sbusy}, 32'd0);
        chk("stall_words", sb.size(), 32'd0);
        sb.push_back(8'hC4);
        sb.push_back(8'hC5);
        drain("stall_tail", 20, n);

        // Abandon: requester 1 then requester 2 drop valid mid-burst.
        put(2, 8'hE2, 1'b0);
        put(3, 8'hE3, 1'b1);
        sb.push_back(8'hE2);
        sb.push_back(8'hE3);
        drive();
        step();
        chk("abandon1_gnt",  {28'b0, sg}, 32'b0010);
        chk("abandon1_winc", {31'b0, sw}, 32'd0);
        step();
        chk("abandon_idle1", {28'b0, sg}, 32'd0);
        step();
        chk("abandon_xfer_gnt",  {28'b0, sg}, 32'b0100);
        chk("abandon_xfer_winc", {31'b0, sw}, 32'd1);
        step();
        chk("abandon2_gnt",  {28'b0, sg}, 32'b0100);
        chk("abandon2_winc", {31'b0, sw}, 32'd0);
        step();
        chk("abandon_idle2", {28'b0, sg}, 32'd0);
        step();
        chk("abandon_next_gnt",  {28'b0, sg}, 32'b1000);
        chk("abandon_next_winc", {31'b0, sw}, 32'd1);

        // Reset asserted during beat 2 of requester 1.
        for (int k = 0; k < 4; k++) put(1, 8'(8'hF0 + k), 1'b0);
        sb.push_back(8'hF0);
        sb.push_back(8'hF1);
        drive();
        step();
        step();
        step();
        chk("mid_pre_winc", {31'b0, winc}, 32'd1);
        #2 wrst_n = 1'b0;
        #1;
        chk("mid_rst_winc",  {31'b0, winc},      32'd0);
        chk("mid_rst_gnt",   {28'b0, gnt},       32'd0);
        chk("mid_rst_ready", {28'b0, req_ready}, 32'd0);
        chk("mid_rst_busy",  {31'b0, busy},      32'd0);
        chk("mid_rst_sb",    sb.size(),          32'd0);
        flush();
        put(0, 8'h60, 1'b1);
        put(1, 8'h61, 1'b1);
        sb.push_back(8'h60);
        sb.push_back(8'h61);
        drive();
        @(negedge wclk);
        #1 wrst_n = 1'b1;
        step();
        chk("post_rst_gnt",  {28'b0, sg}, 32'd1);
        chk("post_rst_winc", {31'b0, sw}, 32'd1);
        drain("post_rst", 20, n);
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin write-port arbiter that shares one write port of the async FIFO among NREQ requesters in the write clock domain.
- Each requester has a valid/ready/last stream interface.
- The arbiter grants one requester at a time for a burst of up to MAXBURST words and drives the FIFO's wdata/winc.
- It never issues winc while wfull is high, so no word is dropped or overwritten.

Parameters:
DSIZE, 8, data word width; must match the FIFO data width.
NREQ, 4, number of requesters; NREQ >= 2.
MAXBURST, 4, maximum words per grant; MAXBURST >= 1.

Ports:
wclk  in  1  write-domain clock; all logic on the rising edge.
wrst_n  in  1  asynchronous active-low reset.
req_valid  in  NREQ  per-requester word-valid.
req_last  in  NREQ  per-requester end-of-packet marker, qualified by valid.
req_data  in  NREQ*DSIZE  requester i data in bits [i*DSIZE +: DSIZE].
req_ready  out  NREQ  per-requester accept; a word transfers when valid & ready.
wfull  in  1  FIFO full flag, registered, wclk domain.
winc  out  1  FIFO write increment.
wdata  out  DSIZE  FIFO write data.
gnt  out  NREQ  one-hot current owner; all zero when idle.
busy  out  1  high while in the BURST state.

Behaviour:
Registered state:
- FSM state (IDLE/BURST).
- owner index, $clog2(NREQ) bits.
- rr_ptr, $clog2(NREQ) bits: highest-priority index.
- beat count, $clog2(MAXBURST+1) bits.

Reset (asynchronous, wrst_n low):
- state=IDLE, owner=0, rr_ptr=0, beat=0.
- Therefore gnt=0, busy=0, req_ready=0, winc=0, wdata=0.

Datapath (combinational from registered state):
- xfer = (state==BURST) & req_valid[owner] & ~wfull.
- winc = xfer.
- req_ready[owner] = xfer; every other req_ready bit = 0.
- wdata = req_data[owner] when state==BURST, else 0.
- gnt = onehot(owner) when state==BURST, else 0.
- busy = (state==BURST).

IDLE:
- If any req_valid is set, select the first set bit scanning from rr_ptr upward, wrapping modulo NREQ.
- Load owner with that index, clear beat, go to BURST.
- Arbitration costs exactly one cycle; no word transfers in IDLE.
- If no req_valid is set, stay in IDLE.

BURST, per cycle:
- xfer & (req_last[owner] | beat==MAXBURST-1): the word is written; go to IDLE; rr_ptr = (owner+1) mod NREQ; beat=0.
- xfer otherwise: beat = beat+1; stay in BURST.
- ~req_valid[owner]: owner abandoned the grant; go to IDLE; rr_ptr = (owner+1) mod NREQ; no write.
- req_valid[owner] & wfull: stall; hold state, owner and beat; winc=0; ready=0. There is no timeout; the grant holds until space frees.

Rules:
- Requesters must hold data and last stable while valid & ~ready.
- The arbiter does not check this.

Boundary conditions:
- Fairness: a requester that keeps valid high is served again only after every other valid requester has had one grant.
- Worst-case wait for a granted requester = (NREQ-1) * (MAXBURST+1) cycles, excluding wfull stalls.
- wfull rising in the same cycle as a planned last word: no transfer; the last word goes out after wfull drops.
- wfull dropping: the transfer happens in the same cycle that wfull is sampled low.
- rr_ptr wrap: owner NREQ-1 → rr_ptr 0.
- Reset asserted mid-burst: outputs clear immediately (asynchronous); the partially sent packet is truncated; the FIFO keeps the words already written.
- Only one winc per cycle. Never winc & wfull in the same cycle (checked by assertion).
- req_last on a non-owner has no effect.
- MAXBURST=1: every granted word ends the burst.

Test Plan:
1. Reset: wrst_n=0 with all req_valid=1 → gnt=0, winc=0, req_ready=0. Release reset → gnt=4'b0001 after 1 cycle.
2. Round-robin: all four requesters valid, no last, wfull=0.
   - Expect gnt sequence 0001,0010,0100,1000,0001.
   - Each grant lasts exactly 4 xfers, with one idle cycle between grants.
3. Early last: requester 2 sends D0=8'hA1 and D1=8'hA2 with last on D1 → winc=2 cycles, wdata A1 then A2, then IDLE with rr_ptr=3.
4. Full stall: mid-burst, drive wfull=1 for 5 cycles.
   - winc=0 and req_ready=0 throughout; beat holds.
   - After wfull drops, the remaining words complete and the total count is 4.
5. Abandon: the owner drops valid after 1 beat → return to IDLE next cycle; the next requester is granted; no write occurs on the abandon cycle.
6. Mid-burst reset: assert wrst_n=0 during beat 2 → winc goes low asynchronously. After release, arbitration restarts from requester 0.
